// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption core: one Feistel round per clock, key schedule walked
// from K16 down to K1 by right-rotating C/D from their unrotated PC1 value.
module des_decrypt_iter #(
  parameter bit CHECK_PARITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:64] ct,
  input  logic [1:64] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:64] pt,
  output logic        key_err
);

  localparam int IP_T [1:64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [1:64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};
  localparam int E_T [1:48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};
  localparam int P_T [1:32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};
  localparam int PC1_T [1:56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [1:48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};
  localparam int SBOX [0:7][0:63] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t      state_reg, state_next;
  logic [1:32] l_reg, l_next, r_reg, r_next;
  logic [1:28] c_reg, c_next, d_reg, d_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [1:64] pt_reg, pt_next;
  logic        kerr_reg, kerr_next;

  logic [1:64] ip_ct, pre_fp, fp_out;
  logic [1:56] pc1_key, cd_rot;
  logic [1:28] c_rot, d_rot;
  logic [1:48] subkey, e_r, x_key;
  logic [1:32] s_out, f_out, r_new;
  logic [1:0]  shift_amt;
  logic [7:0]  byte_odd;
  logic        parity_err;

  genvar gi;

  // Fixed bit permutations are pure wiring.
  for (gi = 1; gi <= 64; gi++) begin : g_ip
    assign ip_ct[gi]  = ct[IP_T[gi]];
    assign fp_out[gi] = pre_fp[FP_T[gi]];
  end
  for (gi = 1; gi <= 56; gi++) begin : g_pc1
    assign pc1_key[gi] = key[PC1_T[gi]];
  end
  for (gi = 1; gi <= 48; gi++) begin : g_pc2_e
    assign subkey[gi] = cd_rot[PC2_T[gi]];
    assign e_r[gi]    = r_reg[E_T[gi]];
  end
  for (gi = 1; gi <= 32; gi++) begin : g_p
    assign f_out[gi] = s_out[P_T[gi]];
  end

  assign x_key = e_r ^ subkey;

  // Row is outer bits (1,6), column is inner bits (2..5).
  for (gi = 0; gi < 8; gi++) begin : g_sbox
    logic [5:0] six;
    assign six = x_key[6*gi+1 +: 6];
    assign s_out[4*gi+1 +: 4] = 4'(SBOX[gi][{six[5], six[0], six[4:1]}]);
  end

  for (gi = 0; gi < 8; gi++) begin : g_parity
    assign byte_odd[gi] = ^key[8*gi+1 +: 8];
  end
  assign parity_err = CHECK_PARITY && (byte_odd != 8'hFF);

  // Reverse schedule: round 1 uses C0/D0 directly (K16 == C0/D0 after 28 left shifts).
  always_comb begin
    shift_amt = 2'd2;
    if (cnt_reg == 5'd1)
      shift_amt = 2'd0;
    else if (cnt_reg == 5'd2 || cnt_reg == 5'd9 || cnt_reg == 5'd16)
      shift_amt = 2'd1;
  end

  always_comb begin
    case (shift_amt)
      2'd0:    begin c_rot = c_reg;                     d_rot = d_reg;                     end
      2'd1:    begin c_rot = {c_reg[28], c_reg[1:27]};  d_rot = {d_reg[28], d_reg[1:27]};  end
      default: begin c_rot = {c_reg[27:28], c_reg[1:26]}; d_rot = {d_reg[27:28], d_reg[1:26]}; end
    endcase
  end

  assign cd_rot = {c_rot, d_rot};
  assign r_new  = l_reg ^ f_out;
  assign pre_fp = {r_new, r_reg};

  always_comb begin
    state_next = state_reg;
    l_next     = l_reg;
    r_next     = r_reg;
    c_next     = c_reg;
    d_next     = d_reg;
    cnt_next   = cnt_reg;
    pt_next    = pt_reg;
    kerr_next  = kerr_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          l_next     = ip_ct[1:32];
          r_next     = ip_ct[33:64];
          c_next     = pc1_key[1:28];
          d_next     = pc1_key[29:56];
          cnt_next   = 5'd1;
          kerr_next  = parity_err;
          state_next = ROUND;
        end
      end
      ROUND: begin
        l_next = r_reg;
        r_next = r_new;
        c_next = c_rot;
        d_next = d_rot;
        if (cnt_reg == 5'd16) begin
          pt_next    = fp_out;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 5'd1;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      l_reg     <= '0;
      r_reg     <= '0;
      c_reg     <= '0;
      d_reg     <= '0;
      cnt_reg   <= '0;
      pt_reg    <= '0;
      kerr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      l_reg     <= l_next;
      r_reg     <= r_next;
      c_reg     <= c_next;
      d_reg     <= d_next;
      cnt_reg   <= cnt_next;
      pt_reg    <= pt_next;
      kerr_reg  <= kerr_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign pt        = pt_reg;
  assign key_err   = kerr_reg;

endmodule

// File: doc/des_decrypt_iter.md
# des_decrypt_iter

Iterative single-block DES decryption core: accepts a 64-bit ciphertext and 64-bit key, runs 16 Feistel rounds one per clock with the key schedule walked in reverse (K16 first), and returns the 64-bit plaintext. Receiver-side counterpart to the encryption round datapath in the evaluation-board DES designs. It sits between the board's host-link block buffer and the result register file. Both sides use a valid/ready handshake.

## Interface
- CHECK_PARITY, default 0: when 1, key odd-parity is checked per byte and reported on key_err. When 0, key_err is tied 0.
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ct/key present.
- in_ready  out  1  core idle and able to accept.
- ct  in  [1:64]  ciphertext, DES bit 1 = MSB.
- key  in  [1:64]  DES key including parity bits 8,16,…,64.
- out_valid  out  1  pt valid.
- out_ready  in  1  consumer accepts pt.
- pt  out  [1:64]  plaintext.
- key_err  out  1  at least one key byte has even parity. Valid with out_valid.

## Operation
- States: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready:
    - L,R ← IP(ct).
    - C,D ← PC1(key), no rotation.
    - Round counter ← 1.
    - key_err latched.
    - Go to ROUND.
- ROUND, round i=1..16:
  - Rotate right C,D by the amounts 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 for i=1..16. Rotation is combinational ahead of PC2.
  - Subkey = PC2(rotated C,D).
  - L ← R; R ← L ^ f(R, subkey).
    - f = E-expansion, XOR subkey, S1–S8, P.
  - Register the rotated C,D.
  - On i=16:
    - pt ← FP(R16‖L16), i.e. the final swap is undone before FP.
    - Go to DONE.
- DONE:
  - out_valid=1, and pt and key_err are held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE.
- No bypass from DONE to accept a new block. in_ready is 0 in ROUND and DONE.
- in_valid during ROUND/DONE is ignored. ct/key are sampled only on the accept edge.
- Round function, S-boxes, IP/FP, PC1/PC2 and E tables are the FIPS 46-3 tables.
- Key parity check: XOR of each key byte must be 1. Otherwise key_err=1. Decryption proceeds regardless.

## Timing
- Reset (async assert, synchronous-safe deassert by upstream):
  - state=IDLE, in_ready=1, out_valid=0, pt=0, key_err=0.
  - Counter and internal L/R/C/D are cleared.
- Reset mid-operation aborts immediately. The block in flight is discarded and no out_valid is produced.
- Accept edge T: the first round is computed on edge T+1 and the 16th round on edge T+16.
- out_valid rises after edge T+16, so latency is 16 cycles from acceptance to out_valid.
- in_ready is low from T+1 through the handshake-out edge. It returns high the cycle after out_valid&&out_ready.
- Minimum spacing between accepts is 18 cycles (16 rounds, 1 DONE, 1 IDLE).
- Backpressure: out_ready low holds DONE indefinitely, with outputs unchanged.
- Round counter is 5 bits, counts 1..16, and never wraps. The counter value 16 triggers the transition to DONE.
- in_ready and out_valid are decoded from the state register, with no combinational path from in_valid or out_ready.

## Test plan
- Basic vector: key=133457799BBCDFF1, ct=85E813540F0AB405 → pt=0123456789ABCDEF, out_valid exactly 16 cycles after accept, key_err=0.
- Second vector, back-to-back with out_ready held 1: key=0E329232EA6D0D73, ct=0000000000000000 → pt=8787878787878787. Next accept occurs no earlier than 18 cycles after the previous one.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - pt stays stable.
  - in_ready stays 0.
  - A new in_valid is ignored.
  - Raising out_ready completes exactly one handshake.
- Parity, CHECK_PARITY=1: key=0000000000000000, any ct → key_err=1 with out_valid. Rerun with key=133457799BBCDFF1 → key_err=0.
- Reset mid-round: assert rst_n=0 at round 8.
  - Outputs go to reset values immediately.
  - After release, in_ready=1 and no stale out_valid appears.
  - A fresh basic vector decrypts correctly.
- Round-trip: 1000 random key/pt pairs encrypted by the reference model, decrypted by the DUT → pt matches.
